// File: rtl/coreriscv_axi4_meta_write_sched.sv
// Round-robin scheduler for the L1 D-cache metadata write port, with a one-entry registered output stage.
// Optional build macro CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN gives refill (requester 0) absolute priority.
module coreriscv_axi4_meta_write_sched #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 19,
  parameter int COH_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [IDX_W-1:0] io_in_0_bits_idx,
  input  logic             io_in_0_bits_way_en,
  input  logic [TAG_W-1:0] io_in_0_bits_data_tag,
  input  logic [COH_W-1:0] io_in_0_bits_data_coh_state,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [IDX_W-1:0] io_in_1_bits_idx,
  input  logic             io_in_1_bits_way_en,
  input  logic [TAG_W-1:0] io_in_1_bits_data_tag,
  input  logic [COH_W-1:0] io_in_1_bits_data_coh_state,
  input  logic             io_in_2_valid,
  output logic             io_in_2_ready,
  input  logic [IDX_W-1:0] io_in_2_bits_idx,
  input  logic             io_in_2_bits_way_en,
  input  logic [TAG_W-1:0] io_in_2_bits_data_tag,
  input  logic [COH_W-1:0] io_in_2_bits_data_coh_state,
  input  logic             io_kill,
  input  logic             io_out_ready,
  output logic             io_out_valid,
  output logic [IDX_W-1:0] io_out_bits_idx,
  output logic             io_out_bits_way_en,
  output logic [TAG_W-1:0] io_out_bits_data_tag,
  output logic [COH_W-1:0] io_out_bits_data_coh_state,
  output logic [1:0]       io_chosen,
  output logic             io_busy
);

  // Handshake: a requester is accepted in a cycle where valid & ready are both high;
  // ready is a function of valid (grant), so requesters must raise valid without waiting for ready.
  // The output stage presents a write while io_out_valid is high and retires it on io_out_ready.

  logic [2:0]       valid_vec;
  logic [2:0]       grant;
  logic [1:0]       win;
  logic             can_load;
  logic             accept;
  logic [IDX_W-1:0] win_idx;
  logic             win_way_en;
  logic [TAG_W-1:0] win_tag;
  logic [COH_W-1:0] win_coh;

  assign valid_vec = {io_in_2_valid, io_in_1_valid, io_in_0_valid};

`ifdef CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN
  // sel_two = 0 prefers requester 1 among the non-refill pair, 1 prefers requester 2.
  logic sel_two;

  always_comb begin
    grant = 3'b000;
    win   = 2'd0;
    if (valid_vec[0]) begin
      grant[0] = 1'b1;
      win      = 2'd0;
    end else if (valid_vec[1] && (!sel_two || !valid_vec[2])) begin
      grant[1] = 1'b1;
      win      = 2'd1;
    end else if (valid_vec[2]) begin
      grant[2] = 1'b1;
      win      = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_two <= 1'b0;
    end else if (accept && (win != 2'd0)) begin
      sel_two <= (win == 2'd1);
    end
  end
`else
  logic [1:0] ptr;

  // Walk candidates from furthest to nearest so the nearest valid one (offset 0) wins.
  always_comb begin
    grant = 3'b000;
    win   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      logic [2:0] sum;
      sum = {1'b0, ptr} + 3'(k);
      if (sum >= 3'd3) sum = sum - 3'd3;
      if (valid_vec[sum[1:0]]) begin
        grant          = 3'b000;
        grant[sum[1:0]] = 1'b1;
        win            = sum[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 2'd0;
    end else if (accept) begin
      ptr <= (win == 2'd2) ? 2'd0 : win + 2'd1;
    end
  end
`endif

  assign can_load = !io_kill && (!io_out_valid || io_out_ready);
  assign accept   = (|valid_vec) && can_load;

  assign io_in_0_ready = grant[0] && can_load;
  assign io_in_1_ready = grant[1] && can_load;
  assign io_in_2_ready = grant[2] && can_load;

  always_comb begin
    win_idx    = io_in_0_bits_idx;
    win_way_en = io_in_0_bits_way_en;
    win_tag    = io_in_0_bits_data_tag;
    win_coh    = io_in_0_bits_data_coh_state;
    case (win)
      2'd1: begin
        win_idx    = io_in_1_bits_idx;
        win_way_en = io_in_1_bits_way_en;
        win_tag    = io_in_1_bits_data_tag;
        win_coh    = io_in_1_bits_data_coh_state;
      end
      2'd2: begin
        win_idx    = io_in_2_bits_idx;
        win_way_en = io_in_2_bits_way_en;
        win_tag    = io_in_2_bits_data_tag;
        win_coh    = io_in_2_bits_data_coh_state;
      end
      default: ;
    endcase
  end

  // Kill beats both accept and drain; payload only moves on accept so it is stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_out_valid               <= 1'b0;
      io_out_bits_idx            <= '0;
      io_out_bits_way_en         <= 1'b0;
      io_out_bits_data_tag       <= '0;
      io_out_bits_data_coh_state <= '0;
      io_chosen                  <= 2'd0;
    end else if (io_kill) begin
      io_out_valid <= 1'b0;
    end else if (accept) begin
      io_out_valid               <= 1'b1;
      io_out_bits_idx            <= win_idx;
      io_out_bits_way_en         <= win_way_en;
      io_out_bits_data_tag       <= win_tag;
      io_out_bits_data_coh_state <= win_coh;
      io_chosen                  <= win;
    end else if (io_out_ready) begin
      io_out_valid <= 1'b0;
    end
  end

  assign io_busy = io_out_valid || (|valid_vec);

endmodule

// File: tb/tb_coreriscv_axi4_meta_write_sched.sv
// Self-checking bench for coreriscv_axi4_meta_write_sched: directed scenarios plus random traffic
// checked every cycle against a queue-free behavioural model of the arbitration rules.
module tb_coreriscv_axi4_meta_write_sched;
  localparam int IDX_W = 7;
  localparam int TAG_W = 19;
  localparam int COH_W = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       in_valid;
  logic [IDX_W-1:0] in_idx [3];
  logic             in_way [3];
  logic [TAG_W-1:0] in_tag [3];
  logic [COH_W-1:0] in_coh [3];
  logic             kill;
  logic             oready;

  logic [2:0]       rdy;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_way;
  logic [TAG_W-1:0] out_tag;
  logic [COH_W-1:0] out_coh;
  logic [1:0]       chosen;
  logic             busy;

  coreriscv_axi4_meta_write_sched #(.IDX_W(IDX_W), .TAG_W(TAG_W), .COH_W(COH_W)) dut (
    .clk(clk), .reset(rst),
    .io_in_0_valid(in_valid[0]), .io_in_0_ready(rdy[0]), .io_in_0_bits_idx(in_idx[0]),
    .io_in_0_bits_way_en(in_way[0]), .io_in_0_bits_data_tag(in_tag[0]),
    .io_in_0_bits_data_coh_state(in_coh[0]),
    .io_in_1_valid(in_valid[1]), .io_in_1_ready(rdy[1]), .io_in_1_bits_idx(in_idx[1]),
    .io_in_1_bits_way_en(in_way[1]), .io_in_1_bits_data_tag(in_tag[1]),
    .io_in_1_bits_data_coh_state(in_coh[1]),
    .io_in_2_valid(in_valid[2]), .io_in_2_ready(rdy[2]), .io_in_2_bits_idx(in_idx[2]),
    .io_in_2_bits_way_en(in_way[2]), .io_in_2_bits_data_tag(in_tag[2]),
    .io_in_2_bits_data_coh_state(in_coh[2]),
    .io_kill(kill), .io_out_ready(oready),
    .io_out_valid(out_valid), .io_out_bits_idx(out_idx), .io_out_bits_way_en(out_way),
    .io_out_bits_data_tag(out_tag), .io_out_bits_data_coh_state(out_coh),
    .io_chosen(chosen), .io_busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: expected output register plus arbitration pointer
  logic             m_valid;
  logic             m_fresh;
  logic [IDX_W-1:0] m_idx;
  logic             m_way;
  logic [TAG_W-1:0] m_tag;
  logic [COH_W-1:0] m_coh;
  int               m_chosen;
  int               m_ptr;     // next requester to search from (plain rr)
  int               m_pref;    // preferred of {1,2} (refill-priority build)
  int               m_win;
  logic             m_accept;

  task automatic model_reset();
    m_valid = 1'b0; m_fresh = 1'b1;
    m_idx = '0; m_way = 1'b0; m_tag = '0; m_coh = '0;
    m_chosen = 0; m_ptr = 0; m_pref = 1;
  endtask

  task automatic model_eval();
    m_win = -1;
`ifdef CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN
    if (in_valid[0]) m_win = 0;
    else if (in_valid[m_pref]) m_win = m_pref;
    else if (in_valid[3 - m_pref]) m_win = 3 - m_pref;
`else
    for (int k = 0; k < 3; k++)
      if (m_win < 0 && in_valid[(m_ptr + k) % 3]) m_win = (m_ptr + k) % 3;
`endif
    m_accept = (m_win >= 0) && !kill && (!m_valid || oready);
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (kill) begin
      m_valid = 1'b0;
    end else if (m_accept) begin
      m_valid = 1'b1; m_fresh = 1'b0;
      m_idx = in_idx[m_win]; m_way = in_way[m_win];
      m_tag = in_tag[m_win]; m_coh = in_coh[m_win];
      m_chosen = m_win;
      m_ptr = (m_win + 1) % 3;
      if (m_win != 0) m_pref = 3 - m_win;
    end else if (oready) begin
      m_valid = 1'b0;
    end
  endtask

  // settle after the falling edge and compare everything the model predicts
  task automatic settle();
    logic [2:0] exp_rdy;
    #1;
    model_eval();
    exp_rdy = 3'b000;
    if (m_accept) exp_rdy[m_win] = 1'b1;
    check("ready", 32'(rdy), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_valid | (|in_valid)));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || m_fresh) begin
      check("out_idx", 32'(out_idx), 32'(m_idx));
      check("out_way", 32'(out_way), 32'(m_way));
      check("out_tag", 32'(out_tag), 32'(m_tag));
      check("out_coh", 32'(out_coh), 32'(m_coh));
      check("chosen", 32'(chosen), 32'(m_chosen));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // driver tasks
  task automatic drive(input logic [2:0] v, input logic k, input logic r);
    in_valid = v; kill = k; oready = r;
  endtask

  task automatic rand_payload();
    for (int n = 0; n < 3; n++) begin
      in_idx[n] = IDX_W'($urandom_range(0, (1 << IDX_W) - 1));
      in_way[n] = 1'($urandom_range(0, 1));
      in_tag[n] = TAG_W'($urandom_range(0, (1 << TAG_W) - 1));
      in_coh[n] = COH_W'($urandom_range(0, (1 << COH_W) - 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    rand_payload();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state and a single probe request
    settle();
    check("reset_chosen", 32'(chosen), 32'd0);
    in_idx[1] = 7'h15; in_tag[1] = 19'h1ABCD; in_coh[1] = 2'b10; in_way[1] = 1'b1;
    drive(3'b010, 1'b0, 1'b1);
    settle();
    check("t1_in1_ready", 32'(rdy[1]), 32'd1);
    advance();
    drive(3'b111, 1'b0, 1'b1);
    settle();
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_idx", 32'(out_idx), 32'h15);
    check("t1_tag", 32'(out_tag), 32'h1ABCD);
    check("t1_chosen", 32'(chosen), 32'd1);
`ifdef CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN
    check("t1_next_grant", 32'(rdy), 32'b001);
`else
    check("t1_next_grant", 32'(rdy), 32'b100);
`endif
    advance();

    // fairness: all valid from reset
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b0, 1'b1);
      rand_payload();
      settle();
`ifdef CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN
      check("rotate", 32'(rdy), 32'b001);
`else
      check("rotate", 32'(rdy), 32'(1 << (i % 3)));
`endif
      advance();
    end

    // stall: entry from requester 2 held while refill waits
    do_reset();
    drive(3'b100, 1'b0, 1'b1);
    settle();
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(3'b001, 1'b0, 1'b0);
      settle();
      check("stall_in0_ready", 32'(rdy[0]), 32'd0);
      check("stall_chosen", 32'(chosen), 32'd2);
      advance();
    end
    drive(3'b001, 1'b0, 1'b1);
    settle();
    check("unstall_in0_ready", 32'(rdy[0]), 32'd1);
    advance();
    drive(3'b000, 1'b0, 1'b0);
    settle();
    check("unstall_chosen", 32'(chosen), 32'd0);
    advance();

    // kill while an entry is pending
    do_reset();
    drive(3'b010, 1'b0, 1'b0);
    settle();
    advance();
    drive(3'b010, 1'b1, 1'b0);
    settle();
    check("kill_in1_ready", 32'(rdy[1]), 32'd0);
    advance();
    drive(3'b000, 1'b0, 1'b0);
    settle();
    check("kill_out_valid", 32'(out_valid), 32'd0);
    advance();

    // reset drops a stalled entry
    drive(3'b100, 1'b0, 1'b0);
    settle();
    advance();
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    settle();
    advance();
    rst = 1'b0;
    drive(3'b110, 1'b0, 1'b1);
    settle();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_chosen", 32'(chosen), 32'd0);
    check("rst_grant_in1", 32'(rdy), 32'b010);
    advance();

    // idle then a single flush request
    for (int i = 0; i < 10; i++) begin
      drive(3'b000, 1'b0, 1'b1);
      settle();
      advance();
    end
    settle();
    check("idle_busy", 32'(busy), 32'd0);
    drive(3'b100, 1'b0, 1'b1);
    settle();
    check("single_busy", 32'(busy), 32'd1);
    advance();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      rst = ($urandom_range(0, 99) == 0);
      drive(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      settle();
      advance();
    end
    rst = 1'b0;
    drive(3'b000, 1'b0, 1'b1);
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/coreriscv_axi4_meta_write_sched.md
Name: coreriscv_axi4_meta_write_sched

Overview:
- Round-robin scheduler that shares the L1 data-cache metadata-array write port among three requesters: 0 = refill, 1 = probe/release, 2 = flush/invalidate.
- Each request carries idx, way_en, tag and coh_state.
- The scheduler registers the winning request in a one-entry output stage, so the write port sees registered data.
- Sits between the cache controller's metadata writers and the metadata SRAM write port.

Parameters:
- IDX_W, 7, set-index width
- TAG_W, 19, tag width
- COH_W, 2, coherence-state width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- io_in_N_valid  input  1  request valid, N = 0..2
- io_in_N_ready  output  1  request accepted this cycle, N = 0..2
- io_in_N_bits_idx  input  IDX_W  set index, N = 0..2
- io_in_N_bits_way_en  input  1  way enable, N = 0..2
- io_in_N_bits_data_tag  input  TAG_W  tag, N = 0..2
- io_in_N_bits_data_coh_state  input  COH_W  coherence state, N = 0..2
- io_kill  input  1  drop the pending output entry and block acceptance this cycle
- io_out_ready  input  1  metadata write port accepts
- io_out_valid  output  1  registered request valid
- io_out_bits_idx  output  IDX_W  registered index
- io_out_bits_way_en  output  1  registered way enable
- io_out_bits_data_tag  output  TAG_W  registered tag
- io_out_bits_data_coh_state  output  COH_W  registered coherence state
- io_chosen  output  2  source of the registered entry (0..2)
- io_busy  output  1  io_out_valid OR any io_in_N_valid

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is synchronous and active-high on reset.
  - On reset: io_out_valid=0, all out bits=0, io_chosen=0, round-robin pointer ptr=0.
  - Reset asserted mid-operation discards the pending entry; no write is issued.
- Arbitration:
  - Search order is ptr, ptr+1, ptr+2 (mod 3). Grant goes to the first valid requester.
  - Grant is combinational from the valids and ptr.
- Ready and accept:
  - can_load = ~io_kill & (~io_out_valid | io_out_ready).
  - io_in_N_ready = grant[N] & can_load. Ready depends on valid; requesters must not wait on ready before asserting valid.
  - Accept = any valid & can_load. At most one requester is accepted per cycle.
- Output register and latency:
  - On accept, the register loads the winner's bits, io_chosen=N and io_out_valid=1.
  - Latency is 1 cycle: accepted in cycle T, presented at T+1.
  - Out bits and io_chosen are held stable while io_out_valid & ~io_out_ready.
  - If io_out_ready and accept occur in the same cycle, the register is replaced. Back-to-back throughput is 1 per cycle.
  - If io_out_ready=1 and there is no accept, io_out_valid goes 0 next cycle. Bits may hold their old value.
- Round-robin pointer:
  - On accept of requester N, ptr := (N+1) mod 3. With no accept, ptr is unchanged.
- Kill:
  - io_kill=1 forces io_out_valid to 0 next cycle and all io_in_N_ready to 0 this cycle. ptr is unchanged.
  - io_kill has priority over io_out_ready and over accept.
- Idle: no valid inputs and an empty register -> no state change.
- Fairness: with all three valid continuously, grants rotate 0,1,2,0,... No requester waits more than 2 accepts.

Optional Feature:
- Macro: CORERISCV_AXI4_META_SCHED_REFILL_PRIO_EN.
- Defined:
  - Requester 0 (refill) has absolute priority whenever valid.
  - Requesters 1 and 2 round-robin between themselves using a 1-bit pointer. Reset value selects 1; on accept of 1 or 2 the pointer selects the other. It is unchanged on accept of 0.
- Undefined: plain 3-way round-robin as in Behaviour.
- The port list is identical in both builds.

Test Plan:
- Reset, then in_1_valid=1, idx=7'h15, tag=19'h1ABCD, coh=2'b10, out_ready=1 -> in_1_ready=1 in cycle 0; cycle 1: out_valid=1, idx=7'h15, tag=19'h1ABCD, chosen=1; ptr=2.
- All three valid continuously, out_ready=1 -> chosen sequence 0,1,2,0,1,2 on consecutive cycles, one accept per cycle. With REFILL_PRIO_EN defined -> 0,0,0,... while in_0 stays valid.
- Registered entry from requester 2, out_ready=0 for 4 cycles, in_0 valid -> in_0_ready=0 for all 4 cycles; out bits stable. Raise out_ready -> in_0 accepted the same cycle; next cycle chosen=0.
- io_kill=1 with out_valid=1 and in_1_valid=1 -> in_1_ready=0; next cycle out_valid=0; ptr unchanged.
- reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, chosen=0; a following in_1 request is granted before a simultaneous in_2 only if in_0 is idle (ptr=0).
- Idle for 10 cycles -> io_busy=0, out_valid=0; then a single in_2 request -> io_busy=1 in the same cycle.
